pattern_scheduler: RTL and testbench

- Selects which test pattern the video datapath drives, using the sync timing from the hvsync generator.
- Patterns are colour bars, grid, solid white and solid black.
- Debounces a front-panel "next" button. Can also auto-advance after a programmable number of frames.
- Commits every pattern change only on a frame boundary so the picture never tears. Also owns the 1 Hz frame heartbeat LED.
- Sits between the board I/O and the pattern mux, in the divided pixel-clock domain.

---
 rtl/video_pkg.sv | 17 +
 rtl/button_debouncer.sv | 46 ++++
 rtl/pattern_scheduler.sv | 120 ++++++++++++
 tb/tb_pattern_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-path definitions: pattern indices, scheduler FSM states and
// the width of the pattern select bus.
package video_pkg;

    localparam int PATTERN_W = 3;

    localparam logic [PATTERN_W-1:0] PAT_BARS  = 3'd0;
    localparam logic [PATTERN_W-1:0] PAT_GRID  = 3'd1;
    localparam logic [PATTERN_W-1:0] PAT_WHITE = 3'd2;
    localparam logic [PATTERN_W-1:0] PAT_BLACK = 3'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sched_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Front-panel button conditioner: 2-flop synchroniser, stable-level counter
// and a one-cycle pulse on each debounced press (0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_level;
    logic [CNT_W-1:0] cnt;

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], btn_raw};
    end

    // Accept a new level only after it has been seen DEBOUNCE_CYCLES edges in
    // a row; any return to the current level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            btn_level <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync_q[1] == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt       <= '0;
                btn_level <= sync_q[1];
                press_evt <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Test-pattern scheduler: turns button presses and an optional auto-advance
// timer into pattern_sel changes committed only on vsync rising edges, and
// drives the frame heartbeat LED.
module pattern_scheduler
    import video_pkg::*;
#(
    parameter int NUM_PATTERNS    = 4,
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int AUTO_FRAMES     = 180,
    parameter int LED_FRAMES      = 30
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vsync,
    input  logic                 btn_next,
    input  logic                 auto_en,
    output logic [PATTERN_W-1:0] pattern_sel,
    output logic                 pattern_update,
    output logic                 frame_led,
    output logic                 busy
);

    localparam int LED_W = (LED_FRAMES  > 1) ? $clog2(LED_FRAMES)  : 1;
    localparam int AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [LED_W-1:0]     LED_MAX  = LED_W'(LED_FRAMES - 1);
    localparam logic [AUTO_W-1:0]    AUTO_MAX = AUTO_W'(AUTO_FRAMES - 1);
    localparam logic [PATTERN_W-1:0] PAT_LAST = PATTERN_W'(NUM_PATTERNS - 1);

    sched_state_e      state, state_nxt;
    logic              vsync_d;
    logic              frame_tick;
    logic              press_evt;
    logic              auto_evt;
    logic              advance;
    logic [LED_W-1:0]  led_cnt;
    logic [AUTO_W-1:0] auto_cnt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_next (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_raw  (btn_next),
        .press_evt(press_evt)
    );

    assign frame_tick = vsync & ~vsync_d;
    assign auto_evt   = frame_tick & auto_en & (auto_cnt == AUTO_MAX);
    assign busy       = (state == PENDING);

    // Delayed vsync for rising-edge detection; a held vsync ticks once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vsync_d <= 1'b0;
        else          vsync_d <= vsync;
    end

    // Heartbeat: toggle the LED every LED_FRAMES frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_cnt   <= '0;
            frame_led <= 1'b0;
        end else if (frame_tick) begin
            if (led_cnt == LED_MAX) begin
                led_cnt   <= '0;
                frame_led <= ~frame_led;
            end else begin
                led_cnt <= led_cnt + 1'b1;
            end
        end
    end

    // Auto-advance frame counter; a committed manual press restarts the
    // interval so the new pattern gets a full AUTO_FRAMES on screen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       auto_cnt <= '0;
        else if (!auto_en)                  auto_cnt <= '0;
        else if (frame_tick && busy)        auto_cnt <= '0;
        else if (auto_evt)                  auto_cnt <= '0;
        else if (frame_tick)                auto_cnt <= auto_cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and advance decision; a press seen on a tick waits for the
    // following frame, and a tick never advances more than once.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (auto_evt)  advance   = 1'b1;
                if (press_evt) state_nxt = PENDING;
            end
            PENDING: begin
                if (frame_tick) begin
                    advance   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered pattern index with wrap, plus the matching update strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_sel    <= PAT_BARS;
            pattern_update <= 1'b0;
        end else begin
            pattern_update <= advance;
            if (advance)
                pattern_sel <= (pattern_sel == PAT_LAST) ? PAT_BARS : pattern_sel + 1'b1;
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: directed scenarios followed by a random phase,
// every cycle compared against a frame/event-level reference model.
module tb_pattern_scheduler;

    localparam int DC = 4, AF = 3, LF = 2, NP = 4;
    localparam int FRAME = 40, VS_LEN = 3;

    logic       clk = 1'b0, reset_n = 1'b0, vsync = 1'b0, btn_next = 1'b0, auto_en = 1'b0;
    logic [2:0] pattern_sel;
    logic       pattern_update, frame_led, busy;

    int vectors = 0, miscompares = 0;
    int ph = 5;
    int ticks = 0, upd_seen = 0;

    // reference model state
    int m_sel, m_acnt, m_lcnt;
    bit m_pend, m_upd, m_led, m_vprev, m_s1, m_s2, m_lvl, m_press;
    bit win[$];

    pattern_scheduler #(
        .NUM_PATTERNS(NP), .DEBOUNCE_CYCLES(DC), .AUTO_FRAMES(AF), .LED_FRAMES(LF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .btn_next(btn_next), .auto_en(auto_en),
        .pattern_sel(pattern_sel), .pattern_update(pattern_update),
        .frame_led(frame_led), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_acnt = 0; m_lcnt = 0;
        m_pend = 0; m_upd = 0; m_led = 0; m_vprev = 0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0;
        win.delete();
    endtask

    // One clock edge of the model, evaluated on pre-edge inputs.
    task automatic model_edge();
        bit tick, aevt, adv, sync, all_diff;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick = vsync && !m_vprev;
        aevt = tick && auto_en && (m_acnt == AF - 1);
        adv  = tick && (m_pend || aevt);
        if (!auto_en || (tick && m_pend) || aevt) m_acnt = 0;
        else if (tick) m_acnt++;
        if (m_pend) m_pend = !tick;
        else        m_pend = m_press;
        m_upd = adv;
        if (adv) m_sel = (m_sel + 1) % NP;
        if (tick) begin
            ticks++;
            m_lcnt++;
            if (m_lcnt == LF) begin
                m_lcnt = 0;
                m_led  = !m_led;
            end
        end
        // button: two-sample delay, then a new level needs DC consecutive
        // samples all different from the current one
        sync = m_s2; m_s2 = m_s1; m_s1 = btn_next;
        m_press = 0;
        win.push_back(sync);
        if (win.size() > DC) void'(win.pop_front());
        if (win.size() == DC) begin
            all_diff = 1;
            foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
            if (all_diff) begin
                m_lvl   = sync;
                m_press = sync;
                win.delete();
            end
        end
        m_vprev = vsync;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("sel", 32'(pattern_sel), 32'(m_sel));
        check("upd", 32'(pattern_update), 32'(m_upd));
        check("led", 32'(frame_led), 32'(m_led));
        check("busy", 32'(busy), 32'(m_pend));
        if (pattern_update) upd_seen++;
        ph    = (ph + 1) % FRAME;
        vsync = (ph < VS_LEN);
    endtask

    task automatic wait_ticks(input int n);
        int start, guard;
        start = ticks;
        guard = 0;
        while ((ticks - start) < n && guard < (n + 1) * FRAME) begin
            cycle();
            guard++;
        end
        if ((ticks - start) < n) begin
            miscompares++;
            $error("FAIL tick_timeout: observed %0d ticks expected %0d", ticks - start, n);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_sel", 32'(pattern_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_upd", 32'(pattern_update), 0);
        check("rst_led", 32'(frame_led), 0);
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int hold;
        int busy_seen;
        model_reset();

        // reset
        repeat (3) cycle();
        reset_n = 1'b1;
        check("reset_sel", 32'(pattern_sel), 0);
        check("reset_upd", 32'(pattern_update), 0);
        check("reset_led", 32'(frame_led), 0);
        check("reset_busy", 32'(busy), 0);

        // idle frames: only the heartbeat moves
        wait_ticks(2);
        check("led_tick2", 32'(frame_led), 1);
        wait_ticks(2);
        check("led_tick4", 32'(frame_led), 0);
        wait_ticks(1);
        check("idle_sel", 32'(pattern_sel), 0);
        check("idle_upd_count", 32'(upd_seen), 0);

        // clean press mid-frame commits on the next tick
        repeat (10) cycle();
        btn_next = 1'b1;
        repeat (10) cycle();
        btn_next = 1'b0;
        repeat (6) cycle();
        check("press_busy", 32'(busy), 1);
        check("press_sel_hold", 32'(pattern_sel), 0);
        wait_ticks(1);
        check("press_commit_sel", 32'(pattern_sel), 1);
        check("press_commit_upd", 32'(pattern_update), 1);
        check("press_commit_busy", 32'(busy), 0);
        cycle();
        check("press_upd_one", 32'(pattern_update), 0);

        // bouncing button never produces a press
        busy_seen = 0;
        for (int i = 0; i < 28; i++) begin
            btn_next = (i < 8) ? ((i / 2) % 2 == 0) : 1'b0;
            cycle();
            if (busy) busy_seen++;
        end
        check("bounce_busy", 32'(busy_seen), 0);
        check("bounce_sel", 32'(pattern_sel), 1);

        // auto mode: advance every AF ticks, including the wrap
        auto_en = 1'b1;
        wait_ticks(3);
        check("auto_t3_sel", 32'(pattern_sel), 2);
        check("auto_t3_upd", 32'(pattern_update), 1);
        wait_ticks(3);
        check("auto_t6_sel", 32'(pattern_sel), 3);
        wait_ticks(3);
        check("auto_t9_wrap", 32'(pattern_sel), 0);
        wait_ticks(3);
        check("auto_t12_sel", 32'(pattern_sel), 1);
        wait_ticks(1);
        check("auto_t13_sel", 32'(pattern_sel), 1);
        check("auto_t13_upd", 32'(pattern_update), 0);

        // press_evt on the same cycle as an auto tick
        auto_en = 1'b0;
        cycle();
        auto_en = 1'b1;
        wait_ticks(2);
        for (int g = 0; g < FRAME && ph != 34; g++) cycle();
        btn_next = 1'b1;
        repeat (7) cycle();
        check("simul_auto_sel", 32'(pattern_sel), 2);
        check("simul_auto_upd", 32'(pattern_update), 1);
        check("simul_pending", 32'(busy), 1);
        btn_next = 1'b0;
        wait_ticks(1);
        check("simul_commit_sel", 32'(pattern_sel), 3);
        check("simul_commit_busy", 32'(busy), 0);
        wait_ticks(2);
        check("simul_t6_sel", 32'(pattern_sel), 3);
        wait_ticks(1);
        check("simul_t7_sel", 32'(pattern_sel), 0);
        check("simul_t7_upd", 32'(pattern_update), 1);

        // reset while a press is pending discards it
        auto_en = 1'b0;
        repeat (10) cycle();
        btn_next = 1'b1;
        repeat (8) cycle();
        btn_next = 1'b0;
        repeat (2) cycle();
        check("pend_busy", 32'(busy), 1);
        pulse_reset();
        wait_ticks(1);
        check("post_rst_sel", 32'(pattern_sel), 0);
        check("post_rst_upd", 32'(pattern_update), 0);

        // random phase
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                btn_next = 1'($urandom_range(1, 0));
                hold     = $urandom_range(12, 1);
            end
            hold--;
            if ($urandom_range(199, 0) == 0) auto_en = ~auto_en;
            if ($urandom_range(399, 0) == 0) pulse_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
